axil_mmio_master: RTL and testbench

//  AXI4-Lite master FSM between the load/store unit's MMIO request path and the GPIO/peripheral

---
 rtl/axil_mmio_master_if.sv | 40 ++++
 rtl/axil_mmio_master.sv | 170 +++++++++++++++++
 tb/tb_axil_mmio_master.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_mmio_master_if.sv
// AXI4-Lite bus between the MMIO master and a peripheral slave.
// Ports (as signals, grouped by channel):
//   aw: awaddr, awvalid, awready
//   w : wdata, wstrb, wvalid, wready
//   b : bresp, bvalid, bready
//   ar: araddr, arvalid, arready
//   r : rdata, rresp, rvalid, rready
// Modports: master drives the address/data/valid/ready-out side, slave the other.
interface axil_mmio_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_mmio_master.sv
// AXI4-Lite master that carries single MMIO loads/stores from the LSU to the
// peripheral region. One transaction in flight; a per-transaction timer aborts
// a transaction whose slave never completes the handshake.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o request handshake (ready only in IDLE)
//   req_we_i, req_addr_i, req_wdata_i, req_wstrb_i  request payload
//   rsp_valid_o             one-cycle completion pulse
//   rsp_rdata_o             data of the last completed read (held)
//   rsp_err_o               SLVERR/DECERR or timeout, valid with rsp_valid_o
//   busy_o                  transaction in progress
//   m_axi                   AXI4-Lite master modport
//
// state | meaning
// IDLE  | waiting for a request, req_ready_o high
// WR    | write address and data channels outstanding
// WB    | waiting for the write response
// RA    | read address outstanding
// RD    | waiting for read data
// RSP   | completion pulse to the LSU
module axil_mmio_master #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                busy_o,
  axil_mmio_master_if.master  m_axi
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned TMR_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RD, S_RSP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                aw_done, w_done;
  logic                err_q, err_nxt;
  logic                capture_r;
  logic [TMR_W-1:0]    tmr;
  logic                accept, aw_hs, w_hs, tmo, counting;

  assign accept   = (state == S_IDLE) && req_valid_i;
  assign aw_hs    = m_axi.awvalid && m_axi.awready;
  assign w_hs     = m_axi.wvalid && m_axi.wready;
  assign counting = (state == S_WR) || (state == S_WB) || (state == S_RA) || (state == S_RD);
  // Down-counter loaded with TIMEOUT_CYC-1 at accept; it reaches 1 in the
  // last bus cycle allowed, so RSP lands exactly TIMEOUT_CYC cycles after accept.
  assign tmo      = (TIMEOUT_CYC != 0) && (tmr <= TMR_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    capture_r = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid_i) state_nxt = req_we_i ? S_WR : S_RA;
      end
      S_WR: begin
        // Handshakes that complete in the expiry cycle still count.
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nxt = S_WB;
        end else if (tmo) begin
          state_nxt = S_RSP;
          err_nxt   = 1'b1;
        end
      end
      S_WB: begin
        if (m_axi.bvalid) begin
          state_nxt = S_RSP;
          err_nxt   = m_axi.bresp[1];
        end else if (tmo) begin
          state_nxt = S_RSP;
          err_nxt   = 1'b1;
        end
      end
      S_RA: begin
        if (m_axi.arready) begin
          state_nxt = S_RD;
        end else if (tmo) begin
          state_nxt = S_RSP;
          err_nxt   = 1'b1;
        end
      end
      S_RD: begin
        if (m_axi.rvalid) begin
          state_nxt = S_RSP;
          err_nxt   = m_axi.rresp[1];
          capture_r = 1'b1;
        end else if (tmo) begin
          state_nxt = S_RSP;
          err_nxt   = 1'b1;
        end
      end
      S_RSP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
      tmr     <= '0;
    end else begin
      err_q <= err_nxt;
      if (capture_r) rdata_q <= m_axi.rdata;
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        wstrb_q <= req_wstrb_i;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        tmr     <= (TIMEOUT_CYC == 0) ? '0 : TMR_W'(TIMEOUT_CYC - 1);
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
        if (counting && (tmr != '0)) tmr <= tmr - TMR_W'(1);
      end
    end
  end

  assign req_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);
  assign rsp_valid_o = (state == S_RSP);
  assign rsp_err_o   = (state == S_RSP) && err_q;
  assign rsp_rdata_o = rdata_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.awvalid = (state == S_WR) && !aw_done;
  assign m_axi.wvalid  = (state == S_WR) && !w_done;
  assign m_axi.bready  = (state == S_WB);
  assign m_axi.arvalid = (state == S_RA);
  assign m_axi.rready  = (state == S_RD);

endmodule

// File: tb/tb_axil_mmio_master.sv
// Directed bench for axil_mmio_master. A reactive slave raises each ready/valid
// a configurable number of cycles after the master asks; the model derives the
// handshake, response and valid windows for each transaction arithmetically
// from those delays, and a per-cycle compare process checks every output.
module tb_axil_mmio_master;
  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_wstrb_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;

  axil_mmio_master_if #(.ADDR_W(32), .DATA_W(32)) bus();

  axil_mmio_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .m_axi(bus)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // slave configuration
  int          s_aw = 0, s_w = 0, s_b = 0, s_ar = 0, s_r = 0;
  logic [1:0]  s_resp = 2'b00;
  logic [31:0] s_rdata = '0;

  // model of the current transaction (absolute cycle numbers)
  int          m_n = -1, m_rsp = -1;
  int          aw_hi = -1, w_hi = -1, b_lo = 0, b_hi = -1, ar_hi = -1, r_lo = 0, r_hi = -1;
  bit          m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  logic [31:0] rd_val = '0, rd_new = '0;
  bit          rd_upd = 1'b0;

  bit          chk_en = 1'b0;
  int          last_rsp = -100;
  logic        last_err = 1'b0;

  // reactive slave
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = '0;
    forever begin
      @(negedge clk_i);
      if (bus.awvalid) begin bus.awready = (aw_cnt >= s_aw); aw_cnt++; end
      else begin bus.awready = 1'b0; aw_cnt = 0; end
      if (bus.wvalid) begin bus.wready = (w_cnt >= s_w); w_cnt++; end
      else begin bus.wready = 1'b0; w_cnt = 0; end
      if (bus.bready) begin bus.bvalid = (b_cnt >= s_b); bus.bresp = s_resp; b_cnt++; end
      else begin bus.bvalid = 1'b0; b_cnt = 0; end
      if (bus.arvalid) begin bus.arready = (ar_cnt >= s_ar); ar_cnt++; end
      else begin bus.arready = 1'b0; ar_cnt = 0; end
      if (bus.rready) begin
        bus.rvalid = (r_cnt >= s_r); bus.rdata = s_rdata; bus.rresp = s_resp; r_cnt++;
      end else begin bus.rvalid = 1'b0; r_cnt = 0; end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk_i) begin
    if (chk_en) begin
      int  c;
      bit  busy_e;
      c = cyc;
      busy_e = (c > m_n) && (c <= m_rsp);
      chk("busy", busy_o, busy_e);
      chk("req_ready", req_ready_o, !busy_e);
      chk("rsp_valid", rsp_valid_o, c == m_rsp);
      chk("rsp_err", rsp_err_o, (c == m_rsp) && m_err);
      chk("rsp_rdata", rsp_rdata_o, (rd_upd && c >= m_rsp) ? rd_new : rd_val);
      chk("awvalid", bus.awvalid, (c > m_n) && (c <= aw_hi));
      chk("wvalid", bus.wvalid, (c > m_n) && (c <= w_hi));
      chk("bready", bus.bready, (c >= b_lo) && (c <= b_hi));
      chk("arvalid", bus.arvalid, (c > m_n) && (c <= ar_hi));
      chk("rready", bus.rready, (c >= r_lo) && (c <= r_hi));
      if ((c > m_n) && (c <= aw_hi)) chk("awaddr", bus.awaddr, m_addr);
      if ((c > m_n) && (c <= w_hi)) begin
        chk("wdata", bus.wdata, m_wdata);
        chk("wstrb", bus.wstrb, m_wstrb);
      end
      if ((c > m_n) && (c <= ar_hi)) chk("araddr", bus.araddr, m_addr);
      if (rsp_valid_o) begin
        last_rsp = c;
        last_err = rsp_err_o;
      end
    end
  end

  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input int awd, input int wdd, input int bd,
                       input int ard, input int rdd, input logic [1:0] resp,
                       input logic [31:0] rdat, input bit poke);
    int n, normal, rsp, a, w, e, bh, ar, rs, rh;
    bit rerr;
    @(negedge clk_i);
    s_aw = awd; s_w = wdd; s_b = bd; s_ar = ard; s_r = rdd; s_resp = resp; s_rdata = rdat;
    rd_val = rd_upd ? rd_new : rd_val;
    rd_upd = 1'b0;
    n = cyc;
    rerr = resp[1];
    a = 0; w = 0; e = 0; bh = 0; ar = 0; rs = 0; rh = 0;
    if (we) begin
      a = n + 1 + awd; w = n + 1 + wdd; e = imax(a, w) + 1; bh = e + bd; normal = bh + 1;
    end else begin
      ar = n + 1 + ard; rs = ar + 1; rh = rs + rdd; normal = rh + 1;
    end
    if (normal <= n + TO) begin
      rsp = normal; m_err = rerr;
      if (!we) begin rd_new = rdat; rd_upd = 1'b1; end
    end else begin
      rsp = n + TO; m_err = 1'b1;
    end
    aw_hi = we ? imin(a, rsp - 1) : -1;
    w_hi  = we ? imin(w, rsp - 1) : -1;
    b_lo  = we ? e : 0;
    b_hi  = we ? imin(bh, rsp - 1) : -1;
    ar_hi = we ? -1 : imin(ar, rsp - 1);
    r_lo  = we ? 0 : rs;
    r_hi  = we ? -1 : imin(rh, rsp - 1);
    m_addr = addr; m_wdata = wd; m_wstrb = st;
    m_n = n; m_rsp = rsp;
    last_rsp = -100;
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd; req_wstrb_i = st;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    if (poke) begin
      // a request while busy must not be latched
      req_valid_i = 1'b1; req_we_i = !we; req_addr_i = 32'hBAD0_0000;
      req_wdata_i = 32'hFFFF_FFFF; req_wstrb_i = 4'hF;
      @(negedge clk_i);
      req_valid_i = 1'b0;
    end
  endtask

  task automatic finish_txn(input int lat, input bit err, input logic [31:0] rdata);
    while (cyc <= m_rsp) @(negedge clk_i);
    chk("latency", last_rsp - m_n, lat);
    chk("err", last_err, err);
    chk("rdata_after", rsp_rdata_o, rdata);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk_i);
    // reset state
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_err", rsp_err_o, 1'b0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
    chk("rst_addr", bus.awaddr, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_en = 1'b1;

    // write, everything ready at once
    issue(1, 32'h3000_0004, 32'h0000_00A5, 4'h1, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    finish_txn(3, 0, 32'h0);
    // W accepted three cycles before AW
    issue(1, 32'h3000_0008, 32'h1122_3344, 4'hF, 3, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    finish_txn(6, 0, 32'h0);
    // read with delayed arready, plus a request while busy
    issue(0, 32'h3000_0000, 32'h0, 4'h0, 0, 0, 0, 2, 0, 2'b00, 32'hDEAD_BEEF, 1);
    finish_txn(5, 0, 32'hDEAD_BEEF);
    // SLVERR read, DECERR write
    issue(0, 32'h3000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b10, 32'h1234_5678, 0);
    finish_txn(3, 1, 32'h1234_5678);
    issue(1, 32'h3000_0014, 32'h5555_AAAA, 4'h3, 0, 0, 0, 0, 0, 2'b11, 32'h0, 1);
    finish_txn(3, 1, 32'h1234_5678);
    // slow but within the timeout
    issue(0, 32'h3000_0020, 32'h0, 4'h0, 0, 0, 0, 0, 4, 2'b00, 32'hCAFE_F00D, 0);
    finish_txn(7, 0, 32'hCAFE_F00D);
    issue(1, 32'h3000_0024, 32'h0BAD_CAFE, 4'hC, 0, 2, 2, 0, 0, 2'b00, 32'h0, 0);
    finish_txn(7, 0, 32'hCAFE_F00D);
    // timeouts: no arready, no awready, no rvalid
    issue(0, 32'h3000_0030, 32'h0, 4'h0, 0, 0, 0, NEVER, 0, 2'b00, 32'h7777_7777, 0);
    finish_txn(8, 1, 32'hCAFE_F00D);
    issue(1, 32'h3000_0034, 32'hA5A5_A5A5, 4'hF, NEVER, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    finish_txn(8, 1, 32'hCAFE_F00D);
    issue(0, 32'h3000_0038, 32'h0, 4'h0, 0, 0, 0, 0, NEVER, 2'b00, 32'h6666_6666, 0);
    finish_txn(8, 1, 32'hCAFE_F00D);

    // reset while waiting for the write response
    issue(1, 32'h3000_0040, 32'h0102_0304, 4'hF, 0, 0, 5, 0, 0, 2'b00, 32'h0, 0);
    repeat (2) @(negedge clk_i);
    chk("pre_rst_bready", bus.bready, 1'b1);
    #1;
    chk_en = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("async_rst_bready", bus.bready, 1'b0);
    chk("async_rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 4'b0);
    chk("async_rst_busy", busy_o, 1'b0);
    chk("async_rst_rdata", rsp_rdata_o, 32'h0);
    m_n = -1; m_rsp = -1; aw_hi = -1; w_hi = -1; b_lo = 0; b_hi = -1;
    ar_hi = -1; r_lo = 0; r_hi = -1; m_err = 1'b0; rd_val = '0; rd_upd = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_req_ready", req_ready_o, 1'b1);
    chk_en = 1'b1;
    issue(1, 32'h3000_0044, 32'h0000_00FF, 4'h1, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    finish_txn(3, 0, 32'h0);
    repeat (2) @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
